// File: rtl/gfx256_wbm_readwrite.sv
// Wishbone B4 classic single-port master for the GFX read/write arbiter.
// One request at a time; completes on slave ack, slave err, or timeout.
module gfx256_wbm_readwrite #(
    parameter int WID     = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 read_request_i,
    input  logic                 write_request_i,
    input  logic [31:0]          addr_i,
    input  logic                 we_i,
    input  logic [WID/8-1:0]     sel_i,
    input  logic [WID-1:0]       dat_i,
    output logic [WID-1:0]       dat_o,
    output logic                 ack_o,
    output logic                 err_o,
    output logic                 busy_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [31:0]          wbm_adr_o,
    output logic [WID/8-1:0]     wbm_sel_o,
    output logic [WID-1:0]       wbm_dat_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic [WID-1:0]       wbm_dat_i
);

    // state  | meaning
    // IDLE   | waiting for a request from the arbiter
    // BUS    | Wishbone cycle in progress, waiting for ack/err/timeout
    // DONE   | ack_o (and err_o) presented to the arbiter for one cycle
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // TIMEOUT=0 still needs a 1-bit counter so the declarations stay legal.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LP_TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [1:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic                r_cyc;
    logic                r_stb;
    logic                r_we;
    logic [31:0]         r_adr;
    logic [WID/8-1:0]    r_sel;
    logic [WID-1:0]      r_wdat;
    logic [WID-1:0]      r_rdat;
    logic                r_ack;
    logic                r_err;
    logic                r_busy;

    logic                w_is_write;
    logic                w_start;
    logic                w_timeout;

    assign w_is_write = write_request_i & we_i;
    assign w_start    = write_request_i | read_request_i;
    assign w_timeout  = (TIMEOUT != 0) && (r_cnt == LP_TO_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_sel   <= '0;
            r_wdat  <= '0;
            r_rdat  <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_adr   <= addr_i;
                        r_sel   <= sel_i;
                        r_wdat  <= dat_i;
                        r_we    <= w_is_write;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_BUS;
                    end
                end
                S_BUS: begin
                    // Error (slave or timeout) outranks a simultaneous ack.
                    if (wbm_err_i || w_timeout) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_rdat  <= '0;
                        r_err   <= 1'b1;
                        r_ack   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (wbm_ack_i) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        if (!r_we) begin
                            r_rdat <= wbm_dat_i;
                        end
                        r_err   <= 1'b0;
                        r_ack   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dat_o     = r_rdat;
    assign ack_o     = r_ack;
    assign err_o     = r_err;
    assign busy_o    = r_busy;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_adr_o = r_adr;
    assign wbm_sel_o = r_sel;
    assign wbm_dat_o = r_wdat;
    assign wbm_cti_o = 3'b000;
    assign wbm_bte_o = 2'b00;

endmodule
